// File: rtl/adder_acc_pkg.sv
// Shared types, reset value and the saturate/wrap helper for adder_acc.
// Saturation is selected by defining ADDER_ACC_SAT_EN.
package pa_adder;

    localparam int unsigned RV_C = 0;
    localparam int unsigned MAXW = 64;

`ifdef ADDER_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic {
        ACC_LOAD = 1'b0,
        ACC_ADD  = 1'b1
    } acc_mode_t;

    // Callers zero-extend to MAXW and truncate the result back.
    function automatic logic [MAXW-1:0] sat_or_wrap(
        input logic            ovf,
        input logic [MAXW-1:0] wrapped,
        input logic [MAXW-1:0] maxv
    );
        return (SAT_EN && ovf) ? maxv : wrapped;
    endfunction

endpackage

// File: rtl/adder_acc_bank.sv
// Per-channel accumulator register file.
// One combinational read port and one write port.
module adder_acc_bank
    import pa_adder::*;
#(
    parameter int unsigned OUT_WIDTH = 7,
    parameter int unsigned NCH       = 4,
    parameter int unsigned CH_W      = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 we_i,
    input  logic [CH_W-1:0]      wch_i,
    input  logic [OUT_WIDTH-1:0] wdata_i,
    input  logic [CH_W-1:0]      rch_i,
    output logic [OUT_WIDTH-1:0] rdata_o
);

    logic [OUT_WIDTH-1:0] mem_q [NCH];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NCH; i++) begin
                mem_q[i] <= OUT_WIDTH'(RV_C);
            end
        end else if (we_i) begin
            mem_q[wch_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rch_i];

endmodule

// File: rtl/adder_acc.sv
// Two-stage multi-channel add/accumulate pipeline with valid/ready handshakes.
// Define ADDER_ACC_SAT_EN for saturating overflow; default is wrap-around.
module adder_acc
    import pa_adder::*;
#(
    parameter  int unsigned WIDTH     = 4,
    parameter  int unsigned OUT_WIDTH = 7,
    parameter  int unsigned NCH       = 4,
    localparam int unsigned CH_W      = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [CH_W-1:0]      ch,
    input  acc_mode_t            acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] c,
    output logic [CH_W-1:0]      out_ch,
    output logic                 ovf
);

    if (OUT_WIDTH < WIDTH + 1) begin : g_err_ow
        $error("adder_acc: OUT_WIDTH must be >= WIDTH+1");
    end
    if (NCH < 2) begin : g_err_nch
        $error("adder_acc: NCH must be >= 2");
    end
    if (OUT_WIDTH >= MAXW) begin : g_err_max
        $error("adder_acc: OUT_WIDTH too large");
    end

    logic en;
    logic take;
    logic ch_ok;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH:0]   s1_sum_q,   s1_sum_d;
    logic [CH_W-1:0]  s1_ch_q,    s1_ch_d;
    acc_mode_t        s1_mode_q,  s1_mode_d;

    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] c_q,         c_d;
    logic [CH_W-1:0]      out_ch_q,    out_ch_d;
    logic                 ovf_q,       ovf_d;

    logic [OUT_WIDTH-1:0] rd_data;
    logic [OUT_WIDTH:0]   nxt;
    logic [OUT_WIDTH-1:0] stored;
    logic                 wr_en;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en && !reset;
    assign take     = in_valid && in_ready;
    assign ch_ok    = 32'(ch) < NCH;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_ch_d    = s1_ch_q;
        s1_mode_d  = s1_mode_q;
        if (en) begin
            // Out-of-range channels are consumed but never reach stage 2.
            s1_valid_d = take && ch_ok;
            s1_sum_d   = (WIDTH+1)'(a) + (WIDTH+1)'(b);
            s1_ch_d    = ch;
            s1_mode_d  = acc;
        end
    end

    adder_acc_bank #(
        .OUT_WIDTH (OUT_WIDTH),
        .NCH       (NCH),
        .CH_W      (CH_W)
    ) u_bank (
        .clk_i   (clk),
        .reset_i (reset),
        .we_i    (wr_en),
        .wch_i   (s1_ch_q),
        .wdata_i (stored),
        .rch_i   (s1_ch_q),
        .rdata_o (rd_data)
    );

    assign nxt = ((s1_mode_q == ACC_ADD) ? (OUT_WIDTH+1)'(rd_data) : '0)
               + (OUT_WIDTH+1)'(s1_sum_q);

    assign stored = OUT_WIDTH'(sat_or_wrap(
        nxt[OUT_WIDTH],
        MAXW'(nxt[OUT_WIDTH-1:0]),
        MAXW'({OUT_WIDTH{1'b1}})
    ));

    assign wr_en = en && s1_valid_q;

    always_comb begin
        out_valid_d = out_valid_q;
        c_d         = c_q;
        out_ch_d    = out_ch_q;
        ovf_d       = ovf_q;
        if (en) begin
            out_valid_d = s1_valid_q;
        end
        if (wr_en) begin
            c_d      = stored;
            out_ch_d = s1_ch_q;
            ovf_d    = nxt[OUT_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_ch_q     <= '0;
            s1_mode_q   <= ACC_LOAD;
            out_valid_q <= 1'b0;
            c_q         <= OUT_WIDTH'(RV_C);
            out_ch_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_ch_q     <= s1_ch_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            out_ch_q    <= out_ch_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign out_ch    = out_ch_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_acc.sv
// Randomised and directed bench for adder_acc against a queue-based model.
// Honours ADDER_ACC_SAT_EN the same way as the design.
module tb_adder_acc;
    import pa_adder::*;

    localparam int OW  = 7;
    localparam int N   = 4;
    localparam int MOD = 1 << OW;
`ifdef ADDER_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [1:0] ch = '0;
    acc_mode_t  acc = ACC_LOAD;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] c;
    logic [1:0] out_ch;
    logic       ovf;

    always #5 clk = ~clk;

    adder_acc #(.WIDTH(4), .OUT_WIDTH(7), .NCH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ch        (ch),
        .acc       (acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .out_ch    (out_ch),
        .ovf       (ovf)
    );

    typedef struct {
        int c;
        int ch;
        int ovf;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   acc_m [N];
    res_t exp_q [$];
    int   obs_c [$];
    int   obs_o [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_beat(input int ia, input int ib, input int ich,
                              input int imode);
        res_t r;
        int   sum;
        sum   = (imode != 0 ? acc_m[ich] : 0) + ia + ib;
        r.ch  = ich;
        r.ovf = (sum >= MOD) ? 1 : 0;
        if (sum >= MOD) r.c = SAT ? MOD - 1 : sum % MOD;
        else            r.c = sum;
        acc_m[ich] = r.c;
        exp_q.push_back(r);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) acc_m[i] = 0;
        exp_q.delete();
    endtask

    task automatic step(input bit v, input int ia, input int ib,
                        input int ich, input int imode, input bit ordy,
                        output bit took, output bit rdy);
        res_t e;
        @(negedge clk);
        in_valid  = v;
        a         = 4'(ia);
        b         = 4'(ib);
        ch        = 2'(ich);
        acc       = acc_mode_t'(imode[0]);
        out_ready = ordy;
        #1;
        rdy  = in_ready;
        took = v && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("c", 32'(c), e.c);
                chk("out_ch", 32'(out_ch), e.ch);
                chk("ovf", 32'(ovf), e.ovf);
                obs_c.push_back(int'(c));
                obs_o.push_back(int'(ovf));
            end
        end
        if (took) model_beat(ia, ib, ich, imode);
    endtask

    task automatic drain(input int n);
        bit t, r;
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 1'b1, t, r);
        chk("drain_empty", exp_q.size(), 32'(0));
        chk("drain_idle", 32'(out_valid), 32'(0));
    endtask

    initial begin
        bit   t, r;
        int   base;
        int   idx;
        int   ch1_c [5];
        int   il [8];
        bit   ordy;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_c", 32'(c), 32'(0));
        chk("rst_out_ch", 32'(out_ch), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'(1));

        // Basic load and latency
        base = obs_c.size();
        step(1'b1, 3, 4, 0, 0, 1'b1, t, r);
        chk("t1_accept", 32'(t), 32'(1));
        step(1'b0, 0, 0, 0, 0, 1'b1, t, r);
        chk("t1_lat_s1", 32'(out_valid), 32'(0));
        step(1'b0, 0, 0, 0, 0, 1'b1, t, r);
        chk("t1_lat_out", 32'(out_valid), 32'(1));
        chk("t1_c", obs_c.size() > base ? obs_c[base] : -1, 32'(7));
        drain(3);

        // ch1 accumulate into overflow
        base = obs_c.size();
        step(1'b1, 15, 15, 1, 0, 1'b1, t, r);
        for (int i = 0; i < 4; i++) step(1'b1, 15, 15, 1, 1, 1'b1, t, r);
        drain(4);
        ch1_c = '{30, 60, 90, 120, SAT ? 127 : 22};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_c%0d", i),
                obs_c.size() > base + i ? obs_c[base+i] : -1, ch1_c[i]);
        end
        chk("t2_ovf", obs_o.size() > base + 4 ? obs_o[base+4] : -1, 32'(1));

        // Stall with three beats offered
        base = obs_c.size();
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            step(idx < 3, idx + 1, idx + 2, 0, 0, 1'b0, t, r);
            if (t) idx++;
            if (i >= 2) chk($sformatf("t3_stall_rdy%0d", i), 32'(r), 32'(0));
        end
        chk("t3_accepted", idx, 32'(2));
        for (int i = 0; i < 10 && idx < 3; i++) begin
            step(1'b1, idx + 1, idx + 2, 0, 0, 1'b1, t, r);
            if (t) idx++;
        end
        chk("t3_third_taken", idx, 32'(3));
        drain(4);
        chk("t3_count", obs_c.size() - base, 32'(3));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_order%0d", i),
                obs_c.size() > base + i ? obs_c[base+i] : -1, 2 * i + 3);
        end

        // Interleaved ch2/ch3 accumulates
        base = obs_c.size();
        for (int i = 0; i < 8; i++) step(1'b1, 1, 1, 2 + (i % 2), 1, 1'b1, t, r);
        drain(4);
        il = '{2, 2, 4, 4, 6, 6, 8, 8};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_c%0d", i),
                obs_c.size() > base + i ? obs_c[base+i] : -1, il[i]);
        end

        // Reset with two beats in flight
        step(1'b1, 9, 9, 0, 0, 1'b0, t, r);
        step(1'b1, 2, 2, 1, 0, 1'b0, t, r);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_post_ready", 32'(in_ready), 32'(1));
        drain(4);
        base = obs_c.size();
        step(1'b1, 1, 0, 2, 1, 1'b1, t, r);
        drain(4);
        chk("t5_acc_c", obs_c.size() > base ? obs_c[base] : -1, 32'(1));

        // Same-channel back-to-back
        base = obs_c.size();
        step(1'b1, 5, 5, 3, 0, 1'b1, t, r);
        step(1'b1, 0, 0, 3, 1, 1'b1, t, r);
        drain(4);
        chk("t6_c1", obs_c.size() > base + 1 ? obs_c[base+1] : -1, 32'(10));

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            ordy = $urandom_range(0, 3) != 0;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 3),
                 $urandom_range(0, 2) != 0, ordy, t, r);
        end
        drain(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
